// File: rtl/onehot_decoder_seq.sv
// Timed one-hot decoder: accepts a binary index over valid/ready and drives the
// matching one-hot line for HOLD cycles, then idles for GAP guard cycles.
module onehot_decoder_seq #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned HOLD  = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             err,
  output logic [7:0]       count
);

  localparam int unsigned CntMax = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic [7:0]       count_q, count_d;
  logic             accept;
  logic             idx_ok;

  assign accept = in_valid && (state_q == StIdle);
  assign idx_ok = 32'(in_idx) < OUT_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // One counter serves both the hold and the gap phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = 1'b0;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (idx_ok) begin
            out_d   = OUT_W'(1) << in_idx;
            cnt_d   = CntW'(HOLD - 1);
            count_d = count_q + 8'd1;
            state_d = StHold;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          out_d = '0;
          if (GAP > 0) begin
            cnt_d   = CntW'(GAP - 1);
            state_d = StGap;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StHold);
    out       = out_q;
    err       = err_q;
    count     = count_q;
  end

endmodule
